adder32_issue_stage: RTL and testbench

Sequential front/back stage wrapped around the combinational Adder32_Extended datapath.
- Accepts add/sub/shift requests on a valid/ready interface and queues them in a small FIFO.
- Issues one request per cycle into an internal Adder32_Extended instance.
- Registers the result with flags and a tag for a downstream valid/ready consumer.
- Gives the previously purely combinational adder a pipelined, back-pressurable interface for the rest of the datapath.

---
 rtl/adder32_issue_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_adder32_issue_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adder32_issue_stage.sv
// ---------------------------------------------------------------------------
// adder32_issue_stage
//
// Puts a registered, back-pressurable wrapper around the combinational
// adder32_extended datapath. Requests enter a small FIFO through a
// valid/ready handshake. One request per cycle is issued from the FIFO head
// into the adder. The result, its flags and the request tag are registered
// for a downstream valid/ready consumer.
//
// Ports:
//   Clk, Rst_n      clock (rising edge), asynchronous active-low reset
//   Flush           synchronous discard of queued and held operations
//   In_Valid/Ready  request handshake (In_Ready = FIFO not full)
//   In_A, In_B      32-bit operands
//   In_Cin          carry-in (add only)
//   In_Mode         00 add, 01 sub, 10 shl 1, 11 lsr 1
//   In_Tag          opaque request tag
//   Out_Valid/Ready result handshake
//   Out_Result      registered result
//   Out_Cout        add carry-out / sub no-borrow / 0 for shifts
//   Out_Zero        result is zero
//   Out_Ovf         signed overflow (add/sub only)
//   Out_Tag         tag of the result
//   Op_Count        wrapping count of completed output handshakes
// ---------------------------------------------------------------------------

// Combinational add/sub/shift datapath with carry, zero and overflow flags.
module adder32_extended (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] result_o,
  output logic        cout_o,
  output logic        zero_o,
  output logic        ovf_o
);

  logic [32:0] sum_s;

  // Mode decode: 33-bit sum keeps the carry; subtraction is A + ~B + 1.
  always_comb begin
    sum_s    = 33'd0;
    result_o = 32'd0;
    cout_o   = 1'b0;
    ovf_o    = 1'b0;
    case (mode_i)
      2'b00: begin
        sum_s    = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
        result_o = sum_s[31:0];
        cout_o   = sum_s[32];
        ovf_o    = (a_i[31] == b_i[31]) && (sum_s[31] != a_i[31]);
      end
      2'b01: begin
        // Carry out of A + ~B + 1 is set exactly when A >= B unsigned.
        sum_s    = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
        result_o = sum_s[31:0];
        cout_o   = sum_s[32];
        ovf_o    = (a_i[31] != b_i[31]) && (sum_s[31] != a_i[31]);
      end
      2'b10: begin
        result_o = {a_i[30:0], 1'b0};
      end
      2'b11: begin
        result_o = {1'b0, a_i[31:1]};
      end
      default: begin
        result_o = 32'd0;
      end
    endcase
    zero_o = (result_o == 32'd0);
  end

endmodule

module adder32_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [31:0]      In_A,
  input  logic [31:0]      In_B,
  input  logic             In_Cin,
  input  logic [1:0]       In_Mode,
  input  logic [TAG_W-1:0] In_Tag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [31:0]      Out_Result,
  output logic             Out_Cout,
  output logic             Out_Zero,
  output logic             Out_Ovf,
  output logic [TAG_W-1:0] Out_Tag,
  output logic [15:0]      Op_Count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             cin;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic             out_cout_q, out_cout_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ovf_q, out_ovf_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [15:0]      op_cnt_q, op_cnt_d;

  logic             in_ready_s;
  logic             push_s;
  logic             load_s;
  logic             out_hs_s;
  req_t             wr_req_s;
  req_t             head_s;
  logic [31:0]      alu_result_s;
  logic             alu_cout_s;
  logic             alu_zero_s;
  logic             alu_ovf_s;

  // Handshake qualifiers; In_Ready depends only on the registered count.
  always_comb begin
    in_ready_s = (cnt_q != CNT_W'(DEPTH));
    push_s     = In_Valid && in_ready_s && !Flush;
    load_s     = (cnt_q != {CNT_W{1'b0}}) && (!out_valid_q || Out_Ready) && !Flush;
    out_hs_s   = out_valid_q && Out_Ready;
    wr_req_s   = '{a: In_A, b: In_B, cin: In_Cin, mode: In_Mode, tag: In_Tag};
    head_s     = fifo_q[rd_ptr_q];
  end

  adder32_extended u_alu (
    .a_i      (head_s.a),
    .b_i      (head_s.b),
    .cin_i    (head_s.cin),
    .mode_i   (head_s.mode),
    .result_o (alu_result_s),
    .cout_o   (alu_cout_s),
    .zero_o   (alu_zero_s),
    .ovf_o    (alu_ovf_s)
  );

  // FIFO pointer/occupancy next state; Flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (Flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (load_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, load_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Output register next state: load captures the head result, else hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;
    out_tag_d    = out_tag_q;
    if (Flush) begin
      out_valid_d = 1'b0;
    end else if (load_s) begin
      out_valid_d = 1'b1;
    end else if (out_hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (load_s) begin
      out_result_d = alu_result_s;
      out_cout_d   = alu_cout_s;
      out_zero_d   = alu_zero_s;
      out_ovf_d    = alu_ovf_s;
      out_tag_d    = head_s.tag;
    end else begin
      out_result_d = out_result_q;
    end
    // A handshake in the Flush cycle still completes and is counted.
    if (out_hs_s) begin
      op_cnt_d = op_cnt_q + 16'd1;
    end else begin
      op_cnt_d = op_cnt_q;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= wr_req_s;
    end
  end

  // FIFO control and output state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_tag_q    <= {TAG_W{1'b0}};
      op_cnt_q     <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
      out_tag_q    <= out_tag_d;
      op_cnt_q     <= op_cnt_d;
    end
  end

  assign In_Ready   = in_ready_s;
  assign Out_Valid  = out_valid_q;
  assign Out_Result = out_result_q;
  assign Out_Cout   = out_cout_q;
  assign Out_Zero   = out_zero_q;
  assign Out_Ovf    = out_ovf_q;
  assign Out_Tag    = out_tag_q;
  assign Op_Count   = op_cnt_q;

endmodule

// File: tb/tb_adder32_issue_stage.sv
// Directed testbench for adder32_issue_stage. Inputs are driven and outputs
// sampled on the falling clock edge, half a period away from the active edge.
module tb_adder32_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cout;
  logic        out_zero;
  logic        out_ovf;
  logic [3:0]  out_tag;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic pend;

  adder32_issue_stage #(.DEPTH(4), .TAG_W(4)) dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .Flush      (flush),
    .In_Valid   (in_valid),
    .In_Ready   (in_ready),
    .In_A       (in_a),
    .In_B       (in_b),
    .In_Cin     (in_cin),
    .In_Mode    (in_mode),
    .In_Tag     (in_tag),
    .Out_Valid  (out_valid),
    .Out_Ready  (out_ready),
    .Out_Result (out_result),
    .Out_Cout   (out_cout),
    .Out_Zero   (out_zero),
    .Out_Ovf    (out_ovf),
    .Out_Tag    (out_tag),
    .Op_Count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Push one request, check 2-cycle latency, the result and the handshake count.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [1:0] mode, input logic [3:0] tag,
                        input logic [31:0] er, input logic ec, input logic ez, input logic eo);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_mode = mode; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({nm, "_valid"},  {31'd0, out_valid}, 32'd1);
    check({nm, "_result"}, out_result, er);
    check({nm, "_cout"},   {31'd0, out_cout}, {31'd0, ec});
    check({nm, "_zero"},   {31'd0, out_zero}, {31'd0, ez});
    check({nm, "_ovf"},    {31'd0, out_ovf},  {31'd0, eo});
    check({nm, "_tag"},    {28'd0, out_tag},  {28'd0, tag});
    @(negedge clk);
    exp_cnt++;
    check({nm, "_op_count"},   {16'd0, op_count}, exp_cnt);
    check({nm, "_valid_done"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
    in_cin = 1'b0; in_mode = 2'b00; in_tag = 4'd0; out_ready = 1'b0; pend = 1'b0;

    // Reset state
    #12;
    check("rst_valid",    {31'd0, out_valid}, 32'd0);
    check("rst_result",   out_result, 32'd0);
    check("rst_flags",    {29'd0, out_cout, out_zero, out_ovf}, 32'd0);
    check("rst_tag",      {28'd0, out_tag}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Arithmetic and shifts
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b00, 4'd3, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("add_cin",  32'h0000_0007, 32'h0000_0008, 1'b1, 2'b00, 4'd6, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2'b00, 4'd2, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 2'b01, 4'd4, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 2'b01, 4'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_zero", 32'h1234_5678, 32'h1234_5678, 1'b0, 2'b01, 4'd9, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("shl",      32'h8000_0001, 32'h0000_0000, 1'b1, 2'b10, 4'd7, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    run_op("shr",      32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 2'b11, 4'd8, 32'h4000_0000, 1'b0, 1'b0, 1'b0);

    // Backpressure: 1 held + 4 queued, then In_Ready drops
    out_ready = 1'b0;
    in_a = 32'd1; in_b = 32'd1; in_cin = 1'b0; in_mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, (i < 5) ? 32'd1 : 32'd0);
      in_tag = 4'(i);
      in_valid = 1'b1;
    end
    @(negedge clk);
    check("bp_held_tag", {28'd0, out_tag}, 32'd0);
    out_ready = 1'b1;
    in_tag = 4'd5;
    #1;
    check("bp_no_comb_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bp_out_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_out_tag_%0d", k), {28'd0, out_tag}, k);
      if (k == 1) check("bp_ready_rise", {31'd0, in_ready}, 32'd1);
      pend = in_valid && in_ready;
      @(negedge clk);
      if (pend) in_valid = 1'b0;
    end
    exp_cnt += 6;
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_op_count", {16'd0, op_count}, exp_cnt);

    // Flush with a held result, 3 queued ops and a push in the flush cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_tag = 4'(8 + i);
    end
    @(negedge clk);
    check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
    check("fl_pre_tag",   {28'd0, out_tag}, 32'd8);
    in_tag = 4'd12; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    exp_cnt++;
    check("fl_valid",    {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check("fl_op_count", {16'd0, op_count}, exp_cnt);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("fl_quiet_%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset while one result is held and two ops are queued
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_tag = 4'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    check("ar_pre_tag",   {28'd0, out_tag}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid",    {31'd0, out_valid}, 32'd0);
    check("ar_tag",      {28'd0, out_tag}, 32'd0);
    check("ar_result",   out_result, 32'd0);
    check("ar_op_count", {16'd0, op_count}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("ar_post_quiet", {31'd0, out_valid}, 32'd0);
    run_op("ar_add", 32'h0000_0010, 32'h0000_0020, 1'b0, 2'b00, 4'd7, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ar_tail_quiet_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    check("ar_final_count", {16'd0, op_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
